detector_scan_scheduler: RTL and testbench

Shares one non-overlapping serial pattern-match engine between two requesters. Each requester presents a 4-bit pattern and a FRAME_LEN-bit frame. A round-robin arbiter grants one requester at a time. The controller then serializes the granted frame LSB-first through the match window and counts non-overlapping occurrences. It returns the count with the winner's id as a one-cycle result pulse, and sits between the stimulus/capture logic and the reporting logic.

---
 rtl/detector_scan_scheduler.sv | 147 ++++++++++++++
 tb/tb_detector_scan_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/detector_scan_scheduler.sv
// Two-requester round-robin front end sharing one serial, non-overlapping
// pattern-match engine; returns the match count tagged with the served id.
module detector_scan_scheduler #(
    parameter int unsigned FRAME_LEN = 20,
    parameter int unsigned PAT_W     = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [PAT_W-1:0]     pattern0,
    input  logic [FRAME_LEN-1:0] frame0,
    input  logic [PAT_W-1:0]     pattern1,
    input  logic [FRAME_LEN-1:0] frame1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic                 res_valid,
    output logic                 res_id,
    output logic [CNT_W-1:0]     res_count
);

    localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state, state_n;
    logic [1:0]           gnt_n;
    logic                 busy_n, res_valid_n, res_id_n;
    logic [CNT_W-1:0]     res_count_n;
    logic [PAT_W-1:0]     window, window_n;
    logic [FILL_W-1:0]    fill, fill_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 last_id, last_id_n;
    logic [PAT_W-1:0]     pat_q, pat_q_n;
    logic [FRAME_LEN-1:0] frame_q, frame_q_n;
    logic [CNT_W-1:0]     count, count_n;

    logic                 win;
    logic [PAT_W-1:0]     win_upd;
    logic [FILL_W-1:0]    fill_upd;
    logic                 match;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_count <= '0;
            window    <= '0;
            fill      <= '0;
            bit_idx   <= '0;
            last_id   <= 1'b1;
            pat_q     <= '0;
            frame_q   <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            busy      <= busy_n;
            res_valid <= res_valid_n;
            res_id    <= res_id_n;
            res_count <= res_count_n;
            window    <= window_n;
            fill      <= fill_n;
            bit_idx   <= bit_idx_n;
            last_id   <= last_id_n;
            pat_q     <= pat_q_n;
            frame_q   <= frame_q_n;
            count     <= count_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        gnt_n       = 2'b00;
        busy_n      = busy;
        res_valid_n = 1'b0;
        res_id_n    = res_id;
        res_count_n = res_count;
        window_n    = window;
        fill_n      = fill;
        bit_idx_n   = bit_idx;
        last_id_n   = last_id;
        pat_q_n     = pat_q;
        frame_q_n   = frame_q;
        count_n     = count;

        // Tie goes to whoever was not served last
        win      = (req == 2'b11) ? ~last_id : req[1];
        win_upd  = {frame_q[bit_idx], window[PAT_W-1:1]};
        fill_upd = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        match    = (fill_upd == FILL_W'(PAT_W)) && (win_upd == pat_q);

        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (req != 2'b00) begin
                    state_n   = S_SCAN;
                    busy_n    = 1'b1;
                    gnt_n     = win ? 2'b10 : 2'b01;
                    last_id_n = win;
                    res_id_n  = win;
                    pat_q_n   = win ? pattern1 : pattern0;
                    frame_q_n = win ? frame1 : frame0;
                    window_n  = '0;
                    fill_n    = '0;
                    count_n   = '0;
                    bit_idx_n = '0;
                end
            end
            S_SCAN: begin
                // A hit consumes the window so the next hit needs fresh bits
                if (match) begin
                    count_n  = (&count) ? count : count + CNT_W'(1);
                    window_n = '0;
                    fill_n   = '0;
                end else begin
                    window_n = win_upd;
                    fill_n   = fill_upd;
                end
                if (bit_idx == IDX_W'(FRAME_LEN - 1)) begin
                    state_n     = S_DONE;
                    res_valid_n = 1'b1;
                    res_count_n = count_n;
                end else begin
                    bit_idx_n = bit_idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_detector_scan_scheduler.sv
// Directed bench for detector_scan_scheduler: arbitration order, latency,
// non-overlapping counts and asynchronous abort.
module tb_detector_scan_scheduler;

    localparam int unsigned FRAME_LEN = 20;
    localparam int unsigned PAT_W     = 4;
    localparam int unsigned CNT_W     = 4;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           req;
    logic [PAT_W-1:0]     pattern0, pattern1;
    logic [FRAME_LEN-1:0] frame0, frame1;
    logic [1:0]           gnt;
    logic                 busy, res_valid, res_id;
    logic [CNT_W-1:0]     res_count;

    int n_cmp;
    int n_err;

    detector_scan_scheduler #(
        .FRAME_LEN(FRAME_LEN),
        .PAT_W    (PAT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .pattern0 (pattern0),
        .frame0   (frame0),
        .pattern1 (pattern1),
        .frame1   (frame1),
        .gnt      (gnt),
        .busy     (busy),
        .res_valid(res_valid),
        .res_id   (res_id),
        .res_count(res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a grant, then for the result, checking timing and values.
    task automatic run_job(input string tag, input logic exp_id,
                           input logic [CNT_W-1:0] exp_cnt, input logic [1:0] clr);
        int lat;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) break;
        end
        check({tag, ".gnt"}, 32'(gnt), exp_id ? 32'h2 : 32'h1);
        check({tag, ".busy"}, 32'(busy), 32'h1);
        req = req & ~clr;
        lat = 0;
        @(negedge clk);
        lat++;
        check({tag, ".gnt_drop"}, 32'(gnt), 32'h0);
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(FRAME_LEN));
        check({tag, ".res_id"}, 32'(res_id), 32'(exp_id));
        check({tag, ".res_count"}, 32'(res_count), 32'(exp_cnt));
        @(negedge clk);
        check({tag, ".valid_drop"}, 32'(res_valid), 32'h0);
        check({tag, ".idle"}, 32'(busy), 32'h0);
        check({tag, ".hold_count"}, 32'(res_count), 32'(exp_cnt));
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        req      = 2'b00;
        pattern0 = '0;
        pattern1 = '0;
        frame0   = '0;
        frame1   = '0;
        #23;
        check("reset.gnt", 32'(gnt), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.res_valid", 32'(res_valid), 32'h0);
        check("reset.res_id", 32'(res_id), 32'h0);
        check("reset.res_count", 32'(res_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: alternating pattern, five disjoint hits
        pattern0 = 4'hA; frame0 = 20'hAAAAA; req = 2'b01;
        run_job("t1", 1'b0, 4'd5, 2'b01);

        // 2: run of seven ones yields one hit, not four
        pattern1 = 4'hF; frame1 = 20'h0007F; req = 2'b10;
        run_job("t2", 1'b1, 4'd1, 2'b10);

        // 3: final hit ends on the last frame bit
        pattern0 = 4'h0; frame0 = 20'h000F0; req = 2'b01;
        run_job("t3", 1'b0, 4'd4, 2'b01);

        // 5: no hits still produces a result strobe
        pattern0 = 4'h5; frame0 = 20'h00000; req = 2'b01;
        run_job("t5", 1'b0, 4'd0, 2'b01);

        // 4: contention after reset alternates 0,1,0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pattern0 = 4'hA; frame0 = 20'hAAAAA;
        pattern1 = 4'hF; frame1 = 20'h0007F;
        @(negedge clk);
        req = 2'b11;
        run_job("t4a", 1'b0, 4'd5, 2'b00);
        run_job("t4b", 1'b1, 4'd1, 2'b00);
        run_job("t4c", 1'b0, 4'd5, 2'b11);

        // 6: abort mid-scan, then the held request reruns from bit 0
        pattern0 = 4'hC; frame0 = 20'hC0C0C; req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) break;
        end
        check("t6.gnt", 32'(gnt), 32'h1);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_busy", 32'(busy), 32'h0);
        check("t6.rst_gnt", 32'(gnt), 32'h0);
        check("t6.rst_res_id", 32'(res_id), 32'h0);
        check("t6.rst_res_count", 32'(res_count), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6.rst_res_valid", 32'(res_valid), 32'h0);
        end
        rst_n = 1'b1;
        run_job("t6r", 1'b0, 4'd3, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
